// File: rtl/hwclock_pkg.sv
// hwclock shared types: FSM state encoding,
// control-word bit indices and default widths.
package hwclock_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int PRE_W_DEF = 32;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_LOAD        = 1;
  localparam int CTRL_ALM_EN      = 2;
  localparam int CTRL_AUTO_RELOAD = 3;
  localparam int CTRL_CLR_FLAG    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/hwclock_if.sv
// Register-side bundle between the AXI slave (master
// modport) and the time-base core (slave modport).
interface hwclock_if #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 32
);

  logic             ctrl_wr;
  logic [31:0]      ctrl_data;
  logic [PRE_W-1:0] prescale;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cmp_val;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             alarm;
  logic             alarm_flag;
  logic             wrap_flag;
  logic [1:0]       state;

  modport master (
    output ctrl_wr, ctrl_data, prescale,
    output load_val, cmp_val,
    input  count, tick, alarm,
    input  alarm_flag, wrap_flag, state
  );

  modport slave (
    input  ctrl_wr, ctrl_data, prescale,
    input  load_val, cmp_val,
    output count, tick, alarm,
    output alarm_flag, wrap_flag, state
  );

endinterface

// File: rtl/hwclock_prescaler.sv
// Prescaler: pre_cnt counts 0..P while en, else held 0.
// Ports: clk, rst, en, prescale in; hit (comb), tick out.
module hwclock_prescaler #(
  parameter int PRE_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  output logic             hit,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  // hit lets the core advance on the same edge
  // that the registered tick goes high.
  assign hit = en & (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= hit;
      if (!en || hit)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/hwclock_core.sv
// Time-base engine: FSM, event counter, alarm, flags.
// Ports: ACLK, ARESET; bus (hwclock_if.slave) for regs.
module hwclock_core
  import hwclock_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input logic      ACLK,
  input logic      ARESET,
  hwclock_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, nxt;
  logic             alarm_q, alarm_d;
  logic             aflag_q, aflag_d;
  logic             wflag_q, wflag_d;
  logic             alm_en_q, alm_en_d;
  logic             auto_q, auto_d;
  logic             wr_off, wr_ld, wr_clr;
  logic             run_step, hit, fire, tick;
  logic             unused_ctrl;

  assign unused_ctrl = &{1'b0, bus.ctrl_data[31:5]};

  assign wr_off = bus.ctrl_wr & ~bus.ctrl_data[CTRL_EN];
  assign wr_ld  = bus.ctrl_wr & bus.ctrl_data[CTRL_LOAD];
  assign wr_clr = bus.ctrl_wr & bus.ctrl_data[CTRL_CLR_FLAG];

  // A control write's mode bits apply on its own edge.
  assign alm_en_d = bus.ctrl_wr ?
    bus.ctrl_data[CTRL_ALM_EN] : alm_en_q;
  assign auto_d = bus.ctrl_wr ?
    bus.ctrl_data[CTRL_AUTO_RELOAD] : auto_q;

  // Disable and load both pre-empt the prescaler.
  assign run_step = (state_q == RUN) & ~wr_off & ~wr_ld;

  assign nxt  = count_q + CNT_W'(1);
  assign fire = hit & alm_en_d & (nxt == bus.cmp_val);

  hwclock_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk      (ACLK),
    .rst      (ARESET),
    .en       (run_step),
    .prescale (bus.prescale),
    .hit      (hit),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    alarm_d = 1'b0;
    aflag_d = aflag_q;
    wflag_d = wflag_q;
    if (wr_clr) begin
      aflag_d = 1'b0;
      wflag_d = 1'b0;
    end
    if (bus.ctrl_wr)
      state_d = bus.ctrl_data[CTRL_EN] ? RUN : IDLE;
    if (wr_ld)
      count_d = bus.load_val;
    if (hit) begin
      count_d = nxt;
      // A reload replaces the 0, so it is not a wrap.
      if (&count_q && !(fire && auto_d))
        wflag_d = 1'b1;
      if (fire) begin
        alarm_d = 1'b1;
        aflag_d = 1'b1;
        if (auto_d)
          count_d = bus.load_val;
        else
          state_d = HOLD;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      count_q  <= '0;
      alarm_q  <= 1'b0;
      aflag_q  <= 1'b0;
      wflag_q  <= 1'b0;
      alm_en_q <= 1'b0;
      auto_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      alarm_q  <= alarm_d;
      aflag_q  <= aflag_d;
      wflag_q  <= wflag_d;
      alm_en_q <= alm_en_d;
      auto_q   <= auto_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.tick       = tick;
  assign bus.alarm      = alarm_q;
  assign bus.alarm_flag = aflag_q;
  assign bus.wrap_flag  = wflag_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_hwclock_core.sv
// Bench for hwclock_core: directed scenarios plus a
// random run against a rule-level reference model.
module tb_hwclock_core;

  logic ACLK = 1'b0;
  logic ARESET;

  hwclock_if #(.CNT_W(32), .PRE_W(32)) bus ();

  hwclock_core #(.CNT_W(32), .PRE_W(32)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_count, m_pre;
  logic [1:0]  m_state;
  logic        m_tick, m_alarm, m_af, m_wf;
  logic        m_alm, m_auto;

  // Reference: one clock edge of the documented rules.
  task automatic model_step();
    logic [31:0] nxt;
    logic w, ld;
    if (ARESET) begin
      m_count = 0; m_pre = 0; m_state = 0;
      m_tick = 0; m_alarm = 0; m_af = 0; m_wf = 0;
      m_alm = 0; m_auto = 0;
      return;
    end
    w  = bus.ctrl_wr;
    ld = w & bus.ctrl_data[1];
    m_tick  = 0;
    m_alarm = 0;
    if (w) begin
      m_alm  = bus.ctrl_data[2];
      m_auto = bus.ctrl_data[3];
      if (bus.ctrl_data[4]) begin
        m_af = 0;
        m_wf = 0;
      end
    end
    if (w && !bus.ctrl_data[0]) begin
      m_state = 0;
      m_pre = 0;
      if (ld) m_count = bus.load_val;
    end else if (ld) begin
      m_state = 1;
      m_pre = 0;
      m_count = bus.load_val;
    end else if (w && m_state != 1) begin
      m_state = 1;
      m_pre = 0;
    end else if (m_state == 1) begin
      if (m_pre == bus.prescale) begin
        m_pre = 0;
        m_tick = 1;
        nxt = m_count + 1;
        if (m_alm && nxt == bus.cmp_val) begin
          m_alarm = 1;
          m_af = 1;
          if (m_auto) begin
            m_count = bus.load_val;
          end else begin
            if (nxt == 0) m_wf = 1;
            m_count = nxt;
            m_state = 2;
          end
        end else begin
          if (nxt == 0) m_wf = 1;
          m_count = nxt;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  task automatic tick_clk();
    model_step();
    @(posedge ACLK);
    #1;
    bus.ctrl_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.ctrl_wr   = 1'b1;
    bus.ctrl_data = d;
    tick_clk();
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    tick_clk();
    tick_clk();
    n_cmp++;
    if (bus.count !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_count: got %h want 0", bus.count);
    end
    n_cmp++;
    if ({bus.tick, bus.alarm} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_pulses: got %b want 00",
               {bus.tick, bus.alarm});
    end
    n_cmp++;
    if ({bus.alarm_flag, bus.wrap_flag} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_flags: got %b want 00",
               {bus.alarm_flag, bus.wrap_flag});
    end
    n_cmp++;
    if (bus.state !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_state: got %0d want 0", bus.state);
    end
    ARESET = 1'b0;
  endtask

  task automatic test_basic();
    int ticks;
    bus.prescale = 3;
    bus.load_val = 32'h10;
    bus.cmp_val  = 0;
    wr(32'h3);
    n_cmp++;
    if (bus.count !== 32'h10 || bus.state !== 2'd1) begin
      n_bad++;
      $display("FAIL basic_load: got %h/%0d want 10/1",
               bus.count, bus.state);
    end
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      tick_clk();
      if (bus.tick) ticks++;
    end
    n_cmp++;
    if (bus.count !== 32'h13) begin
      n_bad++;
      $display("FAIL basic_count: got %h want 13", bus.count);
    end
    n_cmp++;
    if (ticks != 3) begin
      n_bad++;
      $display("FAIL basic_ticks: got %0d want 3", ticks);
    end
    wr(32'h10);
  endtask

  task automatic test_oneshot();
    int n_al;
    bus.prescale = 0;
    bus.load_val = 0;
    bus.cmp_val  = 5;
    wr(32'h7);
    n_al = 0;
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      if (bus.alarm) begin
        n_al++;
        n_cmp++;
        if (bus.count !== 32'd5) begin
          n_bad++;
          $display("FAIL os_alarm_count: got %h want 5",
                   bus.count);
        end
      end
    end
    n_cmp++;
    if (n_al != 1) begin
      n_bad++;
      $display("FAIL os_pulses: got %0d want 1", n_al);
    end
    n_cmp++;
    if (bus.state !== 2'd2 || bus.count !== 32'd5) begin
      n_bad++;
      $display("FAIL os_hold: got %0d/%h want 2/5",
               bus.state, bus.count);
    end
    n_cmp++;
    if (bus.alarm_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL os_flag: got %b want 1", bus.alarm_flag);
    end
    wr(32'h10);
    n_cmp++;
    if (bus.alarm_flag !== 1'b0 || bus.state !== 2'd0) begin
      n_bad++;
      $display("FAIL os_clear: got %b/%0d want 0/0",
               bus.alarm_flag, bus.state);
    end
  endtask

  task automatic test_autoreload();
    int n_al;
    bus.prescale = 1;
    bus.load_val = 2;
    bus.cmp_val  = 4;
    wr(32'hF);
    n_al = 0;
    for (int i = 0; i < 16; i++) begin
      tick_clk();
      if (bus.alarm) n_al++;
      n_cmp++;
      if (bus.alarm !== (i % 4 == 3) ||
          (bus.count !== 32'd2 && bus.count !== 32'd3)) begin
        n_bad++;
        $display("FAIL ar_cycle%0d: got %b/%h want %b/2or3",
                 i, bus.alarm, bus.count, (i % 4 == 3));
      end
    end
    n_cmp++;
    if (n_al != 4 || bus.state !== 2'd1) begin
      n_bad++;
      $display("FAIL ar_total: got %0d/%0d want 4/1",
               n_al, bus.state);
    end
    wr(32'h10);
  endtask

  task automatic test_wrap();
    bus.prescale = 0;
    bus.load_val = 32'hFFFF_FFFE;
    bus.cmp_val  = 0;
    wr(32'h3);
    tick_clk();
    n_cmp++;
    if (bus.count !== 32'hFFFF_FFFF || bus.wrap_flag !== 0) begin
      n_bad++;
      $display("FAIL wrap_pre: got %h/%b want ffffffff/0",
               bus.count, bus.wrap_flag);
    end
    tick_clk();
    n_cmp++;
    if (bus.count !== 32'd0 || bus.wrap_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_post: got %h/%b want 0/1",
               bus.count, bus.wrap_flag);
    end
    wr(32'h10);
  endtask

  task automatic test_collisions();
    bus.prescale = 0;
    bus.load_val = 32'h20;
    bus.cmp_val  = 0;
    wr(32'h3);
    tick_clk();
    tick_clk();
    bus.load_val = 32'h100;
    wr(32'h3);
    n_cmp++;
    if (bus.count !== 32'h100 || bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL col_load_tick: got %h/%b want 100/0",
               bus.count, bus.tick);
    end
    wr(32'h10);
    bus.load_val = 0;
    bus.cmp_val  = 3;
    wr(32'h7);
    tick_clk();
    tick_clk();
    wr(32'h15);
    n_cmp++;
    if (bus.alarm !== 1'b1 || bus.alarm_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL col_clr_alarm: got %b/%b want 1/1",
               bus.alarm, bus.alarm_flag);
    end
    wr(32'h10);
    wr(32'h7);
    tick_clk();
    tick_clk();
    wr(32'h4);
    n_cmp++;
    if (bus.alarm !== 1'b0 || bus.state !== 2'd0 ||
        bus.count !== 32'd2) begin
      n_bad++;
      $display("FAIL col_dis_alarm: got %b/%0d/%h want 0/0/2",
               bus.alarm, bus.state, bus.count);
    end
    wr(32'h10);
  endtask

  task automatic test_back_to_back();
    int n_al;
    bus.prescale = 0;
    bus.load_val = 5;
    bus.cmp_val  = 6;
    wr(32'hF);
    n_al = 0;
    for (int i = 0; i < 8; i++) begin
      tick_clk();
      if (bus.alarm && bus.count == 32'd5) n_al++;
    end
    n_cmp++;
    if (n_al != 8) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %0d want 8", n_al);
    end
    wr(32'h10);
  endtask

  task automatic test_reset_midrun();
    bus.prescale = 0;
    bus.load_val = 32'h50;
    bus.cmp_val  = 0;
    wr(32'h3);
    for (int i = 0; i < 5; i++) tick_clk();
    n_cmp++;
    if (bus.count !== 32'h55) begin
      n_bad++;
      $display("FAIL mid_pre: got %h want 55", bus.count);
    end
    ARESET = 1'b1;
    tick_clk();
    n_cmp++;
    if ({bus.count, bus.tick, bus.alarm, bus.alarm_flag,
         bus.wrap_flag, bus.state} !== 38'd0) begin
      n_bad++;
      $display("FAIL mid_rst: got %h/%0d want 0/0",
               bus.count, bus.state);
    end
    tick_clk();
    tick_clk();
    ARESET = 1'b0;
    tick_clk();
    n_cmp++;
    if (bus.count !== 32'd0 || bus.state !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_after: got %h/%0d want 0/0",
               bus.count, bus.state);
    end
  endtask

  task automatic test_random();
    logic [37:0] got, want;
    logic [31:0] d;
    for (int i = 0; i < 3000; i++) begin
      ARESET = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0)
        bus.prescale = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0)
          bus.load_val = 32'hFFFF_FFF8 + $urandom_range(0, 7);
        else
          bus.load_val = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 7) == 0)
        bus.cmp_val = $urandom_range(0, 20);
      if ($urandom_range(0, 9) == 0) begin
        d = $urandom & 32'h1F;
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        bus.ctrl_wr   = 1'b1;
        bus.ctrl_data = d;
      end
      tick_clk();
      got  = {bus.count, bus.tick, bus.alarm,
              bus.alarm_flag, bus.wrap_flag, bus.state};
      want = {m_count, m_tick, m_alarm, m_af, m_wf, m_state};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL rand_cyc%0d: got %h want %h",
                 i, got, want);
      end
    end
    ARESET = 1'b0;
  endtask

  initial begin
    ARESET        = 1'b1;
    bus.ctrl_wr   = 1'b0;
    bus.ctrl_data = '0;
    bus.prescale  = '0;
    bus.load_val  = '0;
    bus.cmp_val   = '0;
    test_reset();
    test_basic();
    test_oneshot();
    test_autoreload();
    test_wrap();
    test_collisions();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
